serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial adder controller that sequences a single full-adder cell (`full_adder_str`) over `WIDTH` clock cycles to add two `WIDTH`-bit operands. It latches the operands on `start`, feeds one bit pair per cycle LSB-first through the cell, and registers the carry between cycles. It shifts the sum bits into a result register and signals completion with a one-cycle `done` pulse. It serves as the area-minimal arithmetic path alongside the ripple adders in the same core.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2 to 32.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a new operation; sampled only in IDLE.
- `a`  in  WIDTH  operand A; captured on the accepted `start` edge.
- `b`  in  WIDTH  operand B; captured on the accepted `start` edge.
- `sub`  in  1  subtract select; captured with operands; ignored unless `SERIAL_ADDER_SUB_EN` is defined.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse in the DONE state.
- `sum`  out  WIDTH  result; stable from DONE until the next accepted `start`.
- `cout`  out  1  final carry out of the MSB.
- `ovf`  out  1  two's-complement overflow: carry into the MSB XOR carry out of the MSB.

## Operation
- Reset values: state=IDLE, `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0, carry register=0, bit counter=0.
- State machine with three states: IDLE, RUN and DONE.
  - IDLE → RUN when `start`=1. On that edge: latch `a` into shift register A, latch `b` (or ~`b` in subtract mode) into shift register B, load carry register with 0 (or 1 in subtract mode), clear the counter.
  - RUN: each cycle the cell receives A[0], B[0] and the carry register.
    - On each edge, the cell sum shifts into `sum` from the MSB side (`sum` <= {s, sum[WIDTH-1:1]}), A and B shift right by one, the carry register takes the cell carry, and the counter increments.
    - The carry into the MSB is captured when counter = WIDTH-1.
  - RUN → DONE on the edge that processes counter = WIDTH-1. On that edge: `cout` <= cell carry, `ovf` <= captured MSB carry-in XOR cell carry.
  - DONE → IDLE unconditionally after one cycle.
- `start` in RUN or DONE is ignored. There is no queuing; the requester must re-assert `start` in IDLE.
- Operands are don't-care except on the accepted `start` edge.
- `sum`, `cout` and `ovf` hold their values through IDLE until overwritten by the next operation. During RUN, `sum` shows partial shifting contents and is not valid.
- Arithmetic is modulo 2^WIDTH. `cout` is the unsigned carry; in subtract mode `cout`=1 means no borrow.
- Counter width is the minimum needed to count to WIDTH-1. No wrap-around occurs beyond WIDTH-1.

## Timing
- Start accepted at edge k → `busy`=1 for the cycles after edges k .. k+WIDTH-1 → `done`=1 for exactly one cycle after edge k+WIDTH.
- `sum`, `cout` and `ovf` are valid in the same cycle as `done`.
- Throughput: one operation per WIDTH+2 cycles, since `start` is only sampled in IDLE.
- `rst` asserted in any state, including mid-RUN, returns all outputs to reset values on the next edge. The partial result is discarded and no `done` pulse is issued.
- `rst` and `start` asserted on the same edge: `rst` wins.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `SERIAL_ADDER_SUB_EN`.
- When defined, `sub`=1 at the accepted `start` loads ~`b` and presets the carry to 1, producing `a` − `b`. `sub`=0 produces `a` + `b`.
- When undefined, the `sub` port remains present but is ignored. B always loads `b` and the carry always presets to 0; the subtract logic is not synthesized.

## Test plan
- Reset, then idle 5 cycles → `busy`=0, `done`=0, `sum`=0x00, `cout`=0, `ovf`=0.
- WIDTH=8: `a`=200, `b`=100, `start` pulse → `busy` high for 8 cycles, `done` pulse 8 cycles after the start edge, `sum`=0x2C, `cout`=1, `ovf`=0.
- `a`=0x7F, `b`=0x01 → `sum`=0x80, `cout`=0, `ovf`=1. Then `start` held high continuously → a new operation begins only in the cycle after the DONE cycle.
- With `SERIAL_ADDER_SUB_EN`: `a`=5, `b`=7, `sub`=1 → `sum`=0xFE, `cout`=0. Then `a`=7, `b`=5, `sub`=1 → `sum`=0x02, `cout`=1.
- `a`=0xFF, `b`=0x01, `start`; assert `rst` at the 4th RUN cycle → next cycle all outputs are 0, no `done` pulse; a fresh `start` then yields `sum`=0x00, `cout`=1.
- `start` pulsed during RUN with different operands → ignored; the original result and `done` timing are unchanged.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell sequenced LSB-first over WIDTH cycles.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.

module full_adder_str (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);
    logic axb;

    assign axb    = a_i ^ b_i;
    assign s_o    = axb ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & axb);
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH-1:0]   b_load;
    logic               carry_init;
    logic               cell_s;
    logic               cell_c;

`ifdef SERIAL_ADDER_SUB_EN
    // a - b is computed as a + ~b + 1.
    assign b_load     = sub ? ~b : b;
    assign carry_init = sub;
`else
    logic sub_unused;

    assign sub_unused = sub;
    assign b_load     = b;
    assign carry_init = 1'b0;
`endif

    full_adder_str u_cell (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .cin_i  (carry_q),
        .s_o    (cell_s),
        .cout_o (cell_c)
    );

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b_load;
                    carry_d = carry_init;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                sum_d   = {cell_s, sum_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = cell_c;
                if (cnt_q == CNT_LAST) begin
                    // carry_q here is the carry into the MSB.
                    state_d = DONE;
                    cout_d  = cell_c;
                    ovf_d   = carry_q ^ cell_c;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): vector table plus
// hand-written sequences for held start, mid-run reset and ignored start.

module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One operation; inject >= 0 pulses a conflicting start in that RUN cycle.
    task automatic run_op(input string tag, input vec_t v, input int inject);
        int bad;
        bad = 0;
        @(negedge clk);
        a = v.a; b = v.b; sub = v.sub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            if (i == inject) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF; sub = ~v.sub;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " busy_window"}, bad, 0);
        check({tag, " done"}, done, 1);
        check({tag, " busy_off"}, busy, 0);
        check({tag, " sum"}, sum, v.sum);
        check({tag, " cout"}, cout, v.cout);
        check({tag, " ovf"}, ovf, v.ovf);
        @(negedge clk);
        check({tag, " done_pulse_end"}, done, 0);
        check({tag, " sum_hold"}, sum, v.sum);
    endtask

    initial begin
        int bad;
        int done_seen;
        vec_t v;

        vecs.push_back('{8'd200, 8'd100, 1'b0, 8'h2C, 1'b1, 1'b0});
        vecs.push_back('{8'h7F,  8'h01,  1'b0, 8'h80, 1'b0, 1'b1});
        vecs.push_back('{8'hFF,  8'h01,  1'b0, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{8'h80,  8'h80,  1'b0, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{8'h55,  8'hAA,  1'b0, 8'hFF, 1'b0, 1'b0});
        vecs.push_back('{8'h00,  8'h00,  1'b0, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{8'h3C,  8'h0F,  1'b0, 8'h4B, 1'b0, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back('{8'd5,   8'd7,   1'b1, 8'hFE, 1'b0, 1'b0});
        vecs.push_back('{8'd7,   8'd5,   1'b1, 8'h02, 1'b1, 1'b0});
        vecs.push_back('{8'h80,  8'h01,  1'b1, 8'h7F, 1'b1, 1'b1});
`else
        vecs.push_back('{8'd5,   8'd7,   1'b1, 8'h0C, 1'b0, 1'b0});
        vecs.push_back('{8'd7,   8'd5,   1'b1, 8'h0C, 1'b0, 1'b0});
`endif

        rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset sum", sum, 0);
        check("reset cout", cout, 0);
        check("reset ovf", ovf, 0);

        foreach (vecs[k]) run_op($sformatf("vec%0d", k), vecs[k], -1);

        // start held high: second op only accepted in the IDLE cycle after DONE
        @(negedge clk);
        a = 8'h7F; b = 8'h01; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < W; i++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            @(negedge clk);
        end
        check("held busy_window", bad, 0);
        check("held done", done, 1);
        check("held sum", sum, 8'h80);
        @(negedge clk);
        check("held idle_gap", {busy, done}, 2'b00);
        @(negedge clk);
        check("held restart", busy, 1);
        start = 1'b0;
        repeat (W) @(negedge clk);
        check("held second done", done, 1);
        check("held second sum", sum, 8'h80);
        check("held second ovf", ovf, 1);

        // reset in the 4th RUN cycle discards the operation
        @(negedge clk);
        a = 8'hFF; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst outputs", {busy, done, sum, cout, ovf}, 0);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < W + 4; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) done_seen++;
            @(negedge clk);
        end
        check("midrst no_done", done_seen, 0);
        v = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        run_op("after_rst", v, -1);

        // start pulsed during RUN with other operands is ignored
        v = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0};
        run_op("inject", v, 3);
        @(negedge clk);
        check("inject no_restart", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
